// File: rtl/sbox_layer_pkg.sv
// sbox_layer_pkg: constants shared by the S-box and permutation stages
package sbox_layer_pkg;
  localparam int N_SBOX = 33;
  localparam int STATE_W = 8 * N_SBOX;
  localparam logic [7:0] LCNT_INIT_C = 8'h9E;
  // nibble i of the table is S(i), entry 0 in the low nibble
  localparam logic [63:0] SBOX_TABLE = 64'h63C958A7F4120BDE;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[3] ^ l[2] ^ l[1]};
  endfunction
endpackage

// File: rtl/sbox_layer_if.sv
// sbox_layer_if: round request and substituted-state result bundle
interface sbox_layer_if
  import sbox_layer_pkg::*;
#(
  parameter int WIDTH = STATE_W
);
  logic             start;
  logic             round_first;
  logic [WIDTH-1:0] state_in;
  logic [WIDTH-1:0] state_out;
  logic [31:0]      index;
  logic [7:0]       lcounter;
  logic             busy;
  logic             done;
  modport master (output start, round_first, state_in,
                  input state_out, index, lcounter, busy, done);
  modport slave (input start, round_first, state_in,
                 output state_out, index, lcounter, busy, done);
endinterface

// File: rtl/sbox_layer_sbox4.sv
// sbox4: combinational 4-bit S-box lookup
module sbox4
  import sbox_layer_pkg::*;
(
  input  logic [3:0] x,
  output logic [3:0] y
);
  assign y = SBOX_TABLE[4*x +: 4];
endmodule

// File: rtl/sbox_layer.sv
// sbox_layer: lCounter mixing then byte-serial nibble substitution of the round state
module sbox_layer
  import sbox_layer_pkg::*;
#(
  parameter int NSBOX = N_SBOX,
  parameter int WIDTH = 8 * NSBOX,
  parameter logic [7:0] LCNT_INIT = LCNT_INIT_C
) (
  input logic clk,
  input logic rst,
  sbox_layer_if.slave bus
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] work, work_sub, out_q;
  logic [31:0] idx;
  logic [7:0] lcnt_q, lcnt_used, l_use, l_rev, cur, sub;
  logic last;
  assign l_use = bus.round_first ? LCNT_INIT : lcnt_q;
  assign l_rev = {<<{l_use}};
  assign cur = work[8*idx +: 8];
  assign last = idx == 32'(NSBOX - 1);
  sbox4 u_hi (.x(cur[7:4]), .y(sub[7:4]));
  sbox4 u_lo (.x(cur[3:0]), .y(sub[3:0]));
  always_comb begin
    work_sub = work;
    work_sub[8*idx +: 8] = sub;
  end
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE ? (bus.start ? RUN : IDLE)
            : state_q == RUN  ? (last ? DONE : RUN)
            : IDLE;
  end
  // lcnt_used reports the counter of the current/last round; lcnt_q is next round's
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      work      <= '0;
      out_q     <= '0;
      idx       <= '0;
      lcnt_q    <= LCNT_INIT;
      lcnt_used <= LCNT_INIT;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.start) begin
        work      <= bus.state_in ^ WIDTH'(l_use) ^ (WIDTH'(l_rev) << (WIDTH - 8));
        idx       <= '0;
        lcnt_used <= l_use;
      end else if (state_q == RUN) begin
        work <= work_sub;
        idx  <= last ? 32'd0 : idx + 32'd1;
        if (last) begin
          out_q  <= work_sub;
          lcnt_q <= lfsr_step(lcnt_used);
        end
      end
    end
  end
  assign bus.state_out = out_q;
  assign bus.index     = idx;
  assign bus.lcounter  = lcnt_used;
  assign bus.busy      = state_q == RUN;
  assign bus.done      = state_q == DONE;
endmodule

// File: tb/tb_sbox_layer.sv
// tb_sbox_layer: randomized self-checking bench against a behavioural round model
module tb_sbox_layer;
  logic clk = 0;
  logic rst = 0;
  int passed = 0;
  int total = 0;
  logic [7:0] m_lcnt = 8'h9E;
  localparam logic [263:0] ZERO_VEC = {8'hFA, {31{8'hEE}}, 8'hA3};

  always #5 clk = ~clk;

  sbox_layer_if #(.WIDTH(264)) bus ();
  sbox_layer #(.NSBOX(33), .WIDTH(264), .LCNT_INIT(8'h9E)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [263:0] rnd();
    logic [287:0] v = '0;
    for (int i = 0; i < 9; i++) v = {v[255:0], 32'($urandom)};
    return v[263:0];
  endfunction

  function automatic logic [7:0] next_lcnt(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[3] ^ l[2] ^ l[1]};
  endfunction

  function automatic logic [263:0] ref_round(input logic [263:0] s, input logic [7:0] l);
    logic [3:0] tab [16] = '{4'hE, 4'hD, 4'hB, 4'h0, 4'h2, 4'h1, 4'h4, 4'hF,
                             4'h7, 4'hA, 4'h8, 4'h5, 4'h9, 4'hC, 4'h3, 4'h6};
    logic [263:0] x = s;
    x[7:0] = x[7:0] ^ l;
    for (int i = 0; i < 8; i++) x[263-i] = x[263-i] ^ l[i];
    for (int k = 0; k < 66; k++) x[4*k +: 4] = tab[x[4*k +: 4]];
    return x;
  endfunction

  task automatic run_round(input logic rf, input logic [263:0] s, output logic [263:0] got,
                           output int lat, output int bcnt, output logic [7:0] lc,
                           output bit idx_ok, output bit pulse_ok);
    @(posedge clk); #1;
    bus.start = 1; bus.round_first = rf; bus.state_in = s;
    @(posedge clk); #1;
    bus.start = 0; bus.state_in = rnd();
    lat = 1; bcnt = 0; idx_ok = 1; lc = bus.lcounter;
    while (!bus.done && lat < 100) begin
      if (bus.busy) begin
        bcnt++;
        if (bus.index !== 32'(lat - 1)) idx_ok = 0;
      end
      @(posedge clk); #1;
      lat++;
    end
    got = bus.state_out;
    @(posedge clk); #1;
    pulse_ok = !bus.done && !bus.busy && bus.index == 0 && bus.state_out === got;
  endtask

  task automatic test_reset();
    rst = 1; #12;
    total++; if ({bus.state_out, bus.index, bus.busy, bus.done} !== '0)
      $display("FAIL reset_outputs got busy=%b done=%b index=%0d", bus.busy, bus.done, bus.index);
    else passed++;
    total++; if (bus.lcounter !== 8'h9E) $display("FAIL reset_lcounter got %h want 9e", bus.lcounter);
    else passed++;
    @(posedge clk); #1; rst = 0; m_lcnt = 8'h9E;
  endtask

  task automatic test_zero_vector();
    logic [263:0] got; int lat, bcnt; logic [7:0] lc; bit iok, pok;
    run_round(1, '0, got, lat, bcnt, lc, iok, pok);
    m_lcnt = next_lcnt(8'h9E);
    total++; if (lat !== 34) $display("FAIL zero_latency got %0d want 34", lat); else passed++;
    total++; if (bcnt !== 33) $display("FAIL zero_busy got %0d want 33", bcnt); else passed++;
    total++; if (got !== ZERO_VEC) $display("FAIL zero_state got %h want %h", got, ZERO_VEC); else passed++;
    total++; if (!iok) $display("FAIL zero_index_step got nonmonotonic want 0..32"); else passed++;
    total++; if (!pok) $display("FAIL zero_done_pulse got extra done/busy want one pulse"); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [263:0] got, s; int lat, bcnt; logic [7:0] lc; bit iok, pok;
    s = rnd();
    run_round(1, s, got, lat, bcnt, lc, iok, pok);
    total++; if (lc !== 8'h9E) $display("FAIL b2b_lcnt1 got %h want 9e", lc); else passed++;
    total++; if (got !== ref_round(s, 8'h9E)) $display("FAIL b2b_state1 got %h", got); else passed++;
    m_lcnt = next_lcnt(8'h9E);
    s = rnd();
    run_round(0, s, got, lat, bcnt, lc, iok, pok);
    total++; if (lc !== 8'h3C) $display("FAIL b2b_lcnt2 got %h want 3c", lc); else passed++;
    total++; if (got !== ref_round(s, 8'h3C)) $display("FAIL b2b_state2 got %h", got); else passed++;
    m_lcnt = next_lcnt(8'h3C);
  endtask

  task automatic test_start_ignored();
    logic [263:0] s = rnd();
    int dones = 0, bcnt = 0;
    @(posedge clk); #1;
    bus.start = 1; bus.round_first = 1; bus.state_in = s;
    @(posedge clk); #1;
    bus.start = 0;
    for (int c = 0; c < 60; c++) begin
      bus.start = c == 10; bus.state_in = rnd();
      if (bus.busy) bcnt++;
      if (bus.done) dones++;
      @(posedge clk); #1;
    end
    bus.start = 0;
    m_lcnt = next_lcnt(8'h9E);
    total++; if (dones !== 1) $display("FAIL ignore_done_count got %0d want 1", dones); else passed++;
    total++; if (bcnt !== 33) $display("FAIL ignore_busy got %0d want 33", bcnt); else passed++;
    total++; if (bus.state_out !== ref_round(s, 8'h9E))
      $display("FAIL ignore_state got %h want %h", bus.state_out, ref_round(s, 8'h9E));
    else passed++;
  endtask

  task automatic test_mid_reset();
    logic [263:0] got; int lat, bcnt, w = 0; logic [7:0] lc; bit iok, pok;
    @(posedge clk); #1;
    bus.start = 1; bus.round_first = 1'($urandom); bus.state_in = rnd();
    @(posedge clk); #1;
    bus.start = 0;
    while (bus.index !== 32'd17 && w < 100) begin @(posedge clk); #1; w++; end
    total++; if (bus.index !== 32'd17) $display("FAIL midrst_reach got %0d want 17", bus.index); else passed++;
    #2 rst = 1; #1;
    total++; if ({bus.state_out, bus.index, bus.busy, bus.done} !== '0)
      $display("FAIL midrst_outputs got busy=%b done=%b index=%0d", bus.busy, bus.done, bus.index);
    else passed++;
    total++; if (bus.lcounter !== 8'h9E) $display("FAIL midrst_lcnt got %h want 9e", bus.lcounter); else passed++;
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;
    total++; if (bus.busy !== 0 || bus.done !== 0) $display("FAIL midrst_idle got busy=%b done=%b", bus.busy, bus.done);
    else passed++;
    run_round(0, '0, got, lat, bcnt, lc, iok, pok);
    m_lcnt = next_lcnt(8'h9E);
    total++; if (got !== ZERO_VEC) $display("FAIL midrst_replay got %h want %h", got, ZERO_VEC); else passed++;
    total++; if (lat !== 34) $display("FAIL midrst_latency got %0d want 34", lat); else passed++;
  endtask

  task automatic test_random();
    logic [263:0] got, s, exp; int lat, bcnt; logic [7:0] lc, used; bit iok, pok, rf;
    for (int r = 0; r < 1000; r++) begin
      s = rnd(); rf = ($urandom_range(0, 7) == 0);
      used = rf ? 8'h9E : m_lcnt;
      exp = ref_round(s, used);
      run_round(rf, s, got, lat, bcnt, lc, iok, pok);
      m_lcnt = next_lcnt(used);
      total++; if (got !== exp) $display("FAIL rand_state[%0d] got %h want %h", r, got, exp); else passed++;
      total++; if (lc !== used) $display("FAIL rand_lcnt[%0d] got %h want %h", r, lc, used); else passed++;
      total++; if (!iok || lat !== 34 || bcnt !== 33 || !pok)
        $display("FAIL rand_timing[%0d] got lat=%0d busy=%0d idx_ok=%b pulse_ok=%b want 34/33/1/1", r, lat, bcnt, iok, pok);
      else passed++;
    end
  endtask

  initial begin
    bus.start = 0; bus.round_first = 0; bus.state_in = '0;
    test_reset();
    test_zero_vector();
    test_back_to_back();
    test_start_ignored();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sbox_layer.md
SBOX_LAYER -- requirements
Module: sbox_layer

Interface
REQ-001 SHALL have parameter NSBOX, default 33, meaning the number of state bytes; the shared `nSBox constant SHALL be the source for this default.
REQ-002 SHALL have parameter WIDTH, default 264, meaning the state width in bits; it SHALL equal 8*NSBOX.
REQ-003 SHALL have parameter LCNT_INIT, default 8'h9E, meaning the lCounter initial value.
REQ-004 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle request to process one round.
REQ-007 round_first  input  1  sampled with start; when 1, the lCounter SHALL be reloaded with LCNT_INIT before use.
REQ-008 state_in  input  WIDTH  round input state.
REQ-009 state_out  output  WIDTH  substituted state, valid while done=1 and held afterwards.
REQ-010 index  output  32  byte position currently being substituted (0..NSBOX-1); this is the index the downstream pLayer consumes.
REQ-011 lcounter  output  8  lCounter value used in the current or last round.
REQ-012 busy  output  1  high while substitution is in progress.
REQ-013 done  output  1  one-cycle pulse when state_out is valid.

Function
REQ-014 The block SHALL have states IDLE, RUN and DONE: IDLE->RUN on start; RUN->DONE after the byte with index=NSBOX-1 is processed; DONE->IDLE unconditionally after one cycle.
REQ-015 At the start edge in IDLE, the block SHALL load its working register with state_in, XOR the lCounter into bits [7:0] and XOR the bit-reversed lCounter into bits [WIDTH-1:WIDTH-8], and clear index to 0.
REQ-016 The lCounter value used SHALL be LCNT_INIT when round_first=1, and otherwise the stored lCounter.
REQ-017 In RUN, each clock edge SHALL substitute both nibbles of byte[index] through S = {E,D,B,0,2,1,4,F,7,A,8,5,9,C,3,6} (input 0..F) and then increment index.
REQ-018 Latency SHALL be exactly NSBOX+1 cycles from the start edge to done=1, with busy=1 for exactly NSBOX cycles.
REQ-019 On the edge entering DONE, the block SHALL copy the working register to state_out and advance the lCounter one LFSR step: next = {lcnt[6:0], lcnt[7]^lcnt[3]^lcnt[2]^lcnt[1]}.
REQ-020 A start asserted while in RUN or DONE SHALL be ignored, with no queuing.
REQ-021 After the last byte, index SHALL wrap to 0 and hold at 0 in IDLE.
REQ-022 state_out SHALL change only on entry to DONE; state_in changes during RUN SHALL have no effect.
REQ-023 Index arithmetic SHALL be 32-bit unsigned; byte k occupies bits [8k+7:8k].

Reset
REQ-024 Asserting rst at any time, including mid-RUN, SHALL force IDLE with state_out=0, index=0, busy=0, done=0 and lcounter=LCNT_INIT, and SHALL discard the partial round.
REQ-025 After rst deasserts, the first start SHALL behave as a normal round.

Structure
REQ-026 nSBox, the state width, LCNT_INIT and the S-box table SHALL live in the shared constants header that the S-box and permutation stages both include.
REQ-027 The block SHALL contain one sub-module, sbox4, a combinational 4-bit S-box instantiated twice for the two nibbles of the current byte.

Verification
REQ-028 With rst then start, round_first=1, state_in=0: done SHALL assert 34 cycles after the start edge, and state_out SHALL be 0xFA, then 31 bytes of 0xEE, then 0xA3 (MSB to LSB).
REQ-029 With back-to-back rounds and round_first=0 on the second: lcounter SHALL read 0x9E in round 1 and 0x3C in round 2.
REQ-030 With start pulsed at RUN cycle 10: there SHALL be no effect, exactly one done pulse, and busy high for 33 cycles.
REQ-031 With rst asserted while index=17: outputs SHALL be zero, state IDLE, lcounter=0x9E, and the next start SHALL reproduce the REQ-028 result.
REQ-032 With random state_in over 1000 rounds: state_out SHALL match a reference model of constant-XOR followed by the nibble S-box, and index SHALL step 0..32 monotonically during busy.
